// File: rtl/norm_share_arbiter_if.sv
// norm_share_arbiter_if: bundles the lane request bus, the shared Norm
// connection and the downstream result handshake of norm_share_arbiter.
//   req_*   : per-lane valid/ready request with exp_max, fraction_25, tag
//   norm_*  : registered operands to, and combinational result from, Norm
//   out_*   : result valid/ready handshake with exp, fraction, tag, source
// slave  : arbiter view.  master : environment (lanes, Norm, downstream).
interface norm_share_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4,
  parameter int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*8-1:0]     req_exp_max;
  logic [NREQ*25-1:0]    req_fraction_25;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic [7:0]            norm_exp_max;
  logic [24:0]           norm_fraction_25;
  logic [7:0]            norm_exp_out;
  logic [22:0]           norm_fraction_out;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_exp;
  logic [22:0]           out_fraction;
  logic [TAG_W-1:0]      out_tag;
  logic [SRC_W-1:0]      out_src;

  modport slave (
    input  req_valid, req_exp_max, req_fraction_25, req_tag,
    input  norm_exp_out, norm_fraction_out, out_ready,
    output req_ready, norm_exp_max, norm_fraction_25,
    output out_valid, out_exp, out_fraction, out_tag, out_src
  );

  modport master (
    output req_valid, req_exp_max, req_fraction_25, req_tag,
    output norm_exp_out, norm_fraction_out, out_ready,
    input  req_ready, norm_exp_max, norm_fraction_25,
    input  out_valid, out_exp, out_fraction, out_tag, out_src
  );
endinterface

// File: rtl/norm_share_arbiter.sv
// norm_share_arbiter: round-robin sequencer sharing one combinational Norm
// unit between NREQ adder lanes. One request is latched at a time, Norm
// evaluates it from the input register, and the fixed-up result is held
// on out_* until the downstream handshake completes.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : norm_share_arbiter_if.slave (request, Norm and result signals)
module norm_share_arbiter #(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4,
  parameter int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  norm_share_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

  localparam logic [SRC_W:0] NREQ_W = (SRC_W+1)'(NREQ);

  state_t           state_q, state_d;
  logic [SRC_W-1:0] last_q, last_d;
  logic [7:0]       exp_q, exp_d;
  logic [24:0]      frac_q, frac_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic             ovalid_q, ovalid_d;
  logic [7:0]       oexp_q, oexp_d;
  logic [22:0]      ofrac_q, ofrac_d;
  logic [TAG_W-1:0] otag_q, otag_d;
  logic [SRC_W-1:0] osrc_q, osrc_d;

  logic                found;
  logic [SRC_W-1:0]    grant;
  logic [SRC_W:0]      start, sum;
  logic [2*NREQ-1:0]   dbl, shifted;
  logic [NREQ-1:0]     rot;
  logic [7:0]          sel_exp;
  logic [24:0]         sel_frac;
  logic [TAG_W-1:0]    sel_tag;

  // Rotate the valid vector so bit 0 is the lane after last_grant; the
  // doubled copy makes a shift by NREQ identical to a shift by zero.
  always_comb begin
    found   = 1'b0;
    start   = {1'b0, last_q} + (SRC_W+1)'(1);
    sum     = '0;
    dbl     = {bus.req_valid, bus.req_valid};
    shifted = dbl >> start;
    rot     = shifted[NREQ-1:0];
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = start + (SRC_W+1)'(i);
      end
    end
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    grant = sum[SRC_W-1:0];
  end

  always_comb begin
    sel_exp  = '0;
    sel_frac = '0;
    sel_tag  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant == SRC_W'(i)) begin
        sel_exp  = bus.req_exp_max[i*8 +: 8];
        sel_frac = bus.req_fraction_25[i*25 +: 25];
        sel_tag  = bus.req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && found && !rst) bus.req_ready = NREQ'(1) << grant;
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    exp_d    = exp_q;
    frac_d   = frac_q;
    tag_d    = tag_q;
    src_d    = src_q;
    ovalid_d = ovalid_q;
    oexp_d   = oexp_q;
    ofrac_d  = ofrac_q;
    otag_d   = otag_q;
    osrc_d   = osrc_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          exp_d   = sel_exp;
          frac_d  = sel_frac;
          tag_d   = sel_tag;
          src_d   = grant;
          last_d  = grant;
          state_d = EVAL;
        end
      end
      EVAL: begin
        // True zero ignores Norm; an all-ones exponent becomes infinity.
        if (frac_q == '0) begin
          oexp_d  = '0;
          ofrac_d = '0;
        end else if (bus.norm_exp_out == 8'hFF) begin
          oexp_d  = 8'hFF;
          ofrac_d = '0;
        end else begin
          oexp_d  = bus.norm_exp_out;
          ofrac_d = bus.norm_fraction_out;
        end
        otag_d   = tag_q;
        osrc_d   = src_q;
        ovalid_d = 1'b1;
        state_d  = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          ovalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= SRC_W'(NREQ-1);
      exp_q    <= '0;
      frac_q   <= '0;
      tag_q    <= '0;
      src_q    <= '0;
      ovalid_q <= 1'b0;
      oexp_q   <= '0;
      ofrac_q  <= '0;
      otag_q   <= '0;
      osrc_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      exp_q    <= exp_d;
      frac_q   <= frac_d;
      tag_q    <= tag_d;
      src_q    <= src_d;
      ovalid_q <= ovalid_d;
      oexp_q   <= oexp_d;
      ofrac_q  <= ofrac_d;
      otag_q   <= otag_d;
      osrc_q   <= osrc_d;
    end
  end

  assign bus.norm_exp_max     = exp_q;
  assign bus.norm_fraction_25 = frac_q;
  assign bus.out_valid        = ovalid_q;
  assign bus.out_exp          = oexp_q;
  assign bus.out_fraction     = ofrac_q;
  assign bus.out_tag          = otag_q;
  assign bus.out_src          = osrc_q;

endmodule

// File: tb/tb_norm_share_arbiter.sv
// Bench for norm_share_arbiter: lane drivers and a scoreboard monitor that
// predicts grants from a round-robin reference and results from a golden
// Norm plus zero/infinity fix-up.
module tb_norm_share_arbiter;
  localparam int NREQ  = 2;
  localparam int TAG_W = 4;
  localparam int SRC_W = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  norm_share_arbiter_if #(.NREQ(NREQ), .TAG_W(TAG_W), .SRC_W(SRC_W)) bus ();

  norm_share_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .SRC_W(SRC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Golden Norm: carry out shifts right, otherwise shift left to the hidden
  // one; exponent saturates at 8'hFF and floors at 0.
  function automatic logic [30:0] gnorm(input logic [7:0] e, input logic [24:0] f);
    logic [24:0] s;
    int ee;
    s  = f;
    ee = int'(e);
    if (s[24]) begin
      s  = s >> 1;
      ee = ee + 1;
    end else begin
      for (int k = 0; k < 23; k++) begin
        if (!s[23]) begin
          s  = s << 1;
          ee = ee - 1;
        end
      end
    end
    if (ee >= 255) return {8'hFF, 23'h0};
    if (ee <= 0)   return {8'h00, s[22:0]};
    return {ee[7:0], s[22:0]};
  endfunction

  localparam logic [30:0] STUB_VAL = {8'hFF, 23'h2A5A5A};
  logic        stub_ff = 1'b0;
  logic [30:0] norm_res;
  always_comb norm_res = stub_ff ? STUB_VAL : gnorm(bus.norm_exp_max, bus.norm_fraction_25);
  assign bus.norm_exp_out      = norm_res[30:23];
  assign bus.norm_fraction_out = norm_res[22:0];

  typedef struct packed {
    logic [7:0]       e;
    logic [22:0]      f;
    logic [TAG_W-1:0] t;
    logic [SRC_W-1:0] s;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t make_exp(input logic [7:0] e, input logic [24:0] f,
                                    input logic [TAG_W-1:0] t, input int src);
    exp_t        r;
    logic [30:0] n;
    r.t = t;
    r.s = SRC_W'(src);
    if (f == '0) begin
      r.e = '0;
      r.f = '0;
    end else begin
      n = stub_ff ? STUB_VAL : gnorm(e, f);
      if (n[30:23] == 8'hFF) begin
        r.e = 8'hFF;
        r.f = '0;
      end else begin
        r.e = n[30:23];
        r.f = n[22:0];
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model state: 0 idle, 1 evaluating, 2 presenting a result.
  int m_phase = 0;
  int m_last  = NREQ - 1;
  bit prev_rst = 1'b1;
  int acc_cnt[NREQ];

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    int   g;
    int   idx;
    exp_t front;
    if (rst) begin
      chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
      if (prev_rst) chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      m_phase  = 0;
      m_last   = NREQ - 1;
      expq.delete();
      prev_rst = 1'b1;
    end else begin
      prev_rst = 1'b0;
      exp_rdy  = '0;
      g        = -1;
      if (m_phase == 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (g < 0 && bus.req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("out_valid", 64'(bus.out_valid), 64'(m_phase == 2));
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_out", 64'(1), 64'(0));
        end else begin
          front = expq[0];
          chk("out_exp",      64'(bus.out_exp),      64'(front.e));
          chk("out_fraction", 64'(bus.out_fraction), 64'(front.f));
          chk("out_tag",      64'(bus.out_tag),      64'(front.t));
          chk("out_src",      64'(bus.out_src),      64'(front.s));
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (bus.req_ready[i] && bus.req_valid[i]) acc_cnt[i]++;
      case (m_phase)
        0: if (g >= 0) begin
             expq.push_back(make_exp(bus.req_exp_max[g*8 +: 8],
                                     bus.req_fraction_25[g*25 +: 25],
                                     bus.req_tag[g*TAG_W +: TAG_W], g));
             m_last  = g;
             m_phase = 1;
           end
        1: m_phase = 2;
        default: if (bus.out_ready) begin
             if (expq.size() > 0) void'(expq.pop_front());
             m_phase = 0;
           end
      endcase
    end
  end

  // Lane drivers.
  int               acc_used[NREQ];
  logic [7:0]       fx_e[NREQ];
  logic [24:0]      fx_f[NREQ];
  logic [TAG_W-1:0] fx_t[NREQ];

  task automatic present(input int i, input bit fixed);
    logic [7:0]  e;
    logic [24:0] f;
    logic [TAG_W-1:0] t;
    int r;
    if (fixed) begin
      e = fx_e[i];
      f = fx_f[i];
      t = fx_t[i];
    end else begin
      e = ($urandom % 4 == 0) ? 8'(250 + $urandom % 6) : 8'($urandom);
      r = int'($urandom % 8);
      f = (r == 0) ? 25'd0 : (r == 1) ? 25'($urandom % 64) : 25'($urandom);
      t = TAG_W'($urandom);
    end
    bus.req_exp_max[i*8 +: 8]            = e;
    bus.req_fraction_25[i*25 +: 25]      = f;
    bus.req_tag[i*TAG_W +: TAG_W]        = t;
    bus.req_valid[i]                     = 1'b1;
  endtask

  task automatic cycles(input int n, input int p_new, input int p_drop,
                        input int p_ready, input bit fixed);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_cnt[i] != acc_used[i]) begin
          bus.req_valid[i] = 1'b0;
          acc_used[i]      = acc_cnt[i];
        end
        if (!bus.req_valid[i]) begin
          if (int'($urandom % 100) < p_new) present(i, fixed);
        end else if (int'($urandom % 100) < p_drop) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.out_ready = (int'($urandom % 100) < p_ready);
    end
  endtask

  task automatic drain();
    int n;
    bus.req_valid = '0;
    n = 0;
    while (!(m_phase == 0 && expq.size() == 0) && n < 50) begin
      cycles(1, 0, 0, 100, 1'b0);
      n++;
    end
    chk("drain_timeout", 64'(n >= 50), 64'(0));
  endtask

  initial begin
    int n;
    bus.req_valid       = '0;
    bus.req_exp_max     = '0;
    bus.req_fraction_25 = '0;
    bus.req_tag         = '0;
    bus.out_ready       = 1'b1;
    fx_e[0] = 8'd25;  fx_f[0] = 25'b1110111110010110111110010; fx_t[0] = 4'd3;
    fx_e[1] = 8'd125; fx_f[1] = 25'b1001101001100110011001101; fx_t[1] = 4'd5;
    present(0, 1'b1);
    present(1, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Contention: lane 0 first, then alternate.
    cycles(13, 100, 0, 100, 1'b1);
    // Backpressure while both lanes keep requesting.
    cycles(8, 100, 0, 0, 1'b1);
    cycles(6, 100, 0, 100, 1'b1);
    drain();

    // Single request on lane 0.
    present(0, 1'b1);
    cycles(6, 0, 0, 100, 1'b1);
    drain();

    // True zero.
    fx_f[0] = 25'd0;
    fx_e[0] = 8'd125;
    present(0, 1'b1);
    cycles(6, 0, 0, 100, 1'b1);
    drain();

    // Norm forced to overflow.
    stub_ff = 1'b1;
    cycles(20, 60, 0, 70, 1'b0);
    drain();
    stub_ff = 1'b0;

    // Reset while a request is being evaluated.
    n = 0;
    while (m_phase != 1 && n < 20) begin
      cycles(1, 100, 0, 100, 1'b0);
      n++;
    end
    chk("eval_timeout", 64'(n >= 20), 64'(0));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cycles(8, 100, 0, 100, 1'b0);

    // Random traffic with drops and backpressure.
    cycles(1500, 40, 5, 60, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
